subreg_tim_meas: RTL and testbench
==================================

SUBREG_TIM_MEAS -- requirements
Module: SUBREG_TIM_MEAS

Interface
REQ-001 SHALL have parameter C_PERIOD_W, default 31, the width of all count and result fields.
REQ-002 SHALL have port CK_i, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port XARST_i, input, 1 bit: reset, asynchronous, active-low; default pulled high when unconnected.
REQ-004 SHALL have port EN_CK_i, input, 1 bit: clock enable; default pulled high.
REQ-005 SHALL have port RST_i, input, 1 bit: synchronous restart; default pulled low.
REQ-006 SHALL have port PULSE_i, input, 1 bit: pulse train under test, one pulse per enabled cycle sampled high.
REQ-007 SHALL have port GATE_i, input, C_PERIOD_W bits: measurement window length in enabled cycles.
REQ-008 SHALL have port PULSE_N_o, output, C_PERIOD_W bits: pulse count of the last completed window.
REQ-009 SHALL have port GAP_MIN_o, output, C_PERIOD_W bits: smallest pulse-to-pulse gap of the last window.
REQ-010 SHALL have port GAP_MAX_o, output, C_PERIOD_W bits: largest gap of the last window.
REQ-011 SHALL have port REGULAR_o, output, 1 bit: high when the last window was subregular.
REQ-012 SHALL have port OVF_o, output, 1 bit: gap saturation occurred in the last window.
REQ-013 SHALL have port DONE_o, output, 1 bit: one-cycle result strobe.

Function
REQ-014 SHALL advance all internal state only on CK_i edges where EN_CK_i=1; cycles with EN_CK_i=0 are not counted.
REQ-015 SHALL sample GATE_i at the first enabled cycle of each window; a GATE_i change mid-window takes effect at the next window.
REQ-016 SHALL hold idle while the sampled GATE_i=0: no counting and no DONE_o; it re-samples GATE_i every enabled cycle while idle.
REQ-017 SHALL count window position 0..GATE-1; PULSE_i=1 at any enabled position increments the window pulse count.
REQ-018 SHALL define the gap as the number of enabled cycles from one PULSE_i=1 to the next (adjacent pulses give gap 1).
REQ-019 SHALL run the gap counter continuously across window boundaries and attribute each gap to the window containing its closing pulse.
REQ-020 SHALL not measure the first pulse after reset or RST_i as a gap.
REQ-021 SHALL clear min/max tracking at each window start.
REQ-022 SHALL saturate the gap counter at 2^C_PERIOD_W-1; reaching saturation sets the window's overflow flag.
REQ-023 SHALL, on the edge processing position GATE-1 (that cycle's pulse included), load PULSE_N_o, GAP_MIN_o, GAP_MAX_o, REGULAR_o and OVF_o and assert DONE_o for exactly one CK_i cycle; the next window starts on the following enabled cycle.
REQ-024 SHALL set REGULAR_o=1 when at least one gap was measured in the window and GAP_MAX-GAP_MIN<=1, else 0.
REQ-025 SHALL output GAP_MIN_o=GAP_MAX_o=0 and REGULAR_o=0 when no gap closed in the window.
REQ-026 SHALL hold all result outputs stable between DONE_o strobes.
REQ-027 SHALL, on RST_i=1 with EN_CK_i=1, clear window, pulse and gap state and restart at position 0 without asserting DONE_o, retaining the previous results.

Reset
REQ-028 SHALL, while XARST_i=0, force PULSE_N_o, GAP_MIN_o, GAP_MAX_o to 0, force REGULAR_o, OVF_o, DONE_o to 0, and clear all counters and gap history.
REQ-029 SHALL start a new window at position 0 on the first enabled cycle after XARST_i rises.
REQ-030 SHALL abandon a window interrupted by XARST_i or RST_i with no partial result.

Verification
REQ-031 Bench SHALL drive PULSE_i from SUBREG_TIM_DIV (PERIOD 7, PULSE_N 3, C_PERIOD_W 8) with GATE_i=70 -> PULSE_N_o=30, GAP_MIN_o=2, GAP_MAX_o=3, REGULAR_o=1, OVF_o=0.
REQ-032 Bench SHALL hold PULSE_i=1 constant with GATE_i=16 -> PULSE_N_o=16, GAP_MIN_o=GAP_MAX_o=1, REGULAR_o=1, DONE_o every 16 cycles.
REQ-033 Bench SHALL drive pulses with alternating gaps 1 and 5 and GATE_i=24 -> GAP_MIN_o=1, GAP_MAX_o=5, REGULAR_o=0.
REQ-034 Bench SHALL set C_PERIOD_W=4, send one pulse, then 20 idle cycles with GATE_i=15 -> OVF_o=1 in the window where saturation occurs, gap held at 15.
REQ-035 Bench SHALL toggle EN_CK_i 50% with GATE_i=10 -> DONE_o after 10 enabled cycles (about 20 CK_i cycles), with counts identical to the EN_CK_i=1 case.
REQ-036 Bench SHALL pulse XARST_i low mid-window and separately RST_i high mid-window -> XARST_i: outputs zero; RST_i: previous results retained; in both cases no DONE_o until a full GATE_i window later.

Source files
------------

// File: rtl/subreg_tim_meas.sv
// Pulse-train window meter: counts pulses and tracks the min/max pulse-to-pulse
// gap over a GATE_i-long window of enabled cycles, publishing results on DONE_o.
module subreg_tim_meas #(
    parameter int C_PERIOD_W = 31
) (
    input  logic                  CK_i,
    input  logic                  XARST_i,
    input  logic                  EN_CK_i,
    input  logic                  RST_i,
    input  logic                  PULSE_i,
    input  logic [C_PERIOD_W-1:0] GATE_i,
    output logic [C_PERIOD_W-1:0] PULSE_N_o,
    output logic [C_PERIOD_W-1:0] GAP_MIN_o,
    output logic [C_PERIOD_W-1:0] GAP_MAX_o,
    output logic                  REGULAR_o,
    output logic                  OVF_o,
    output logic                  DONE_o
);

    localparam logic [C_PERIOD_W-1:0] ONE     = C_PERIOD_W'(1);
    localparam logic [C_PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                state;
    logic [C_PERIOD_W-1:0] gate_q, pos_q, cnt_q, gap_q, min_q, max_q;
    logic                  gap_valid_q, any_q, ovf_q;

    logic                  start, closes, sat, any_b, ovf_b, any_n, ovf_n, last, regular_n;
    logic [C_PERIOD_W-1:0] gate_eff, pos_b, cnt_b, min_b, max_b;
    logic [C_PERIOD_W-1:0] cnt_n, min_n, max_n, gap_n;

    // The "_b" values are the window tracking state as seen by this cycle: a
    // window-start cycle sees cleared tracking and the freshly sampled GATE_i.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch is inferred.
        start    = (state == ST_IDLE);
        gate_eff = start ? GATE_i : gate_q;
        pos_b    = start ? '0 : pos_q;
        cnt_b    = start ? '0 : cnt_q;
        min_b    = start ? '0 : min_q;
        max_b    = start ? '0 : max_q;
        any_b    = start ? 1'b0 : any_q;
        ovf_b    = start ? 1'b0 : ovf_q;

        closes = PULSE_i && gap_valid_q;
        sat    = gap_valid_q && !PULSE_i && (gap_q >= CNT_MAX - ONE);

        cnt_n  = cnt_b + C_PERIOD_W'(PULSE_i);
        min_n  = (closes && (!any_b || gap_q < min_b)) ? gap_q : min_b;
        max_n  = (closes && (!any_b || gap_q > max_b)) ? gap_q : max_b;
        any_n  = any_b | closes;
        ovf_n  = ovf_b | sat;
        last   = (pos_b == gate_eff - ONE);
        regular_n = any_n && ((max_n - min_n) <= ONE);

        if (PULSE_i)
            gap_n = ONE;
        else if (!gap_valid_q)
            gap_n = '0;
        else if (gap_q == CNT_MAX)
            gap_n = CNT_MAX;
        else
            gap_n = gap_q + ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values regardless of statement order.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state       <= ST_IDLE;
            gate_q      <= '0;
            pos_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            gap_valid_q <= 1'b0;
            any_q       <= 1'b0;
            ovf_q       <= 1'b0;
            PULSE_N_o   <= '0;
            GAP_MIN_o   <= '0;
            GAP_MAX_o   <= '0;
            REGULAR_o   <= 1'b0;
            OVF_o       <= 1'b0;
            DONE_o      <= 1'b0;
        end else begin
            DONE_o <= 1'b0;
            if (EN_CK_i) begin
                if (RST_i) begin
                    // Abandon the window; published results stay as they are.
                    state       <= ST_IDLE;
                    pos_q       <= '0;
                    cnt_q       <= '0;
                    gap_q       <= '0;
                    min_q       <= '0;
                    max_q       <= '0;
                    gap_valid_q <= 1'b0;
                    any_q       <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (gate_eff != '0) begin
                    gap_q       <= gap_n;
                    gap_valid_q <= gap_valid_q | PULSE_i;
                    if (last) begin
                        PULSE_N_o <= cnt_n;
                        GAP_MIN_o <= min_n;
                        GAP_MAX_o <= max_n;
                        REGULAR_o <= regular_n;
                        OVF_o     <= ovf_n;
                        DONE_o    <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state  <= ST_RUN;
                        gate_q <= gate_eff;
                        pos_q  <= pos_b + ONE;
                        cnt_q  <= cnt_n;
                        min_q  <= min_n;
                        max_q  <= max_n;
                        any_q  <= any_n;
                        ovf_q  <= ovf_n;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_subreg_tim_meas.sv
// Scoreboard bench for subreg_tim_meas: the driver queues hand-computed window
// results with their due cycle, a monitor pops and compares on every DONE_o.
module tb_subreg_tim_meas;

    typedef struct {
        int pulse_n;
        int gmin;
        int gmax;
        int regular;
        int ovf;
        int due;
    } exp_t;

    logic       ck = 1'b0;
    logic       xarst, en, rst, p8, p4;
    logic [7:0] gate8;
    logic [3:0] gate4;
    logic       stim_done = 1'b0;

    logic [7:0] pn8, gmin8, gmax8;
    logic       reg8, ovf8, done8;
    logic [3:0] pn4, gmin4, gmax4;
    logic       reg4, ovf4, done4;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q4[$];

    subreg_tim_meas #(.C_PERIOD_W(8)) dut8 (
        .CK_i(ck), .XARST_i(xarst), .EN_CK_i(en), .RST_i(rst), .PULSE_i(p8), .GATE_i(gate8),
        .PULSE_N_o(pn8), .GAP_MIN_o(gmin8), .GAP_MAX_o(gmax8),
        .REGULAR_o(reg8), .OVF_o(ovf8), .DONE_o(done8)
    );

    subreg_tim_meas #(.C_PERIOD_W(4)) dut4 (
        .CK_i(ck), .XARST_i(xarst), .EN_CK_i(en), .RST_i(rst), .PULSE_i(p4), .GATE_i(gate4),
        .PULSE_N_o(pn4), .GAP_MIN_o(gmin4), .GAP_MAX_o(gmax4),
        .REGULAR_o(reg4), .OVF_o(ovf4), .DONE_o(done4)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare(input string tag, input int pn, input int gmin, input int gmax,
                           input int rg, input int ov, input exp_t e);
        check({tag, "_pulse_n"}, pn, e.pulse_n);
        check({tag, "_gap_min"}, gmin, e.gmin);
        check({tag, "_gap_max"}, gmax, e.gmax);
        check({tag, "_regular"}, rg, e.regular);
        check({tag, "_ovf"}, ov, e.ovf);
    endtask

    // Monitor: sole owner of the counters and the held-result models.
    initial begin
        exp_t e;
        exp_t held8;
        exp_t held4;
        exp_t zero_e;
        zero_e = '{default: 0};
        held8  = zero_e;
        held4  = zero_e;
        forever begin
            @(negedge ck);
            if (!xarst) begin
                held8 = zero_e;
                held4 = zero_e;
                compare("rst8", int'(pn8), int'(gmin8), int'(gmax8), int'(reg8), int'(ovf8), zero_e);
                compare("rst4", int'(pn4), int'(gmin4), int'(gmax4), int'(reg4), int'(ovf4), zero_e);
                check("rst8_done", int'(done8), 0);
                check("rst4_done", int'(done4), 0);
            end else begin
                if (done8) begin
                    if (q8.size() == 0) begin
                        check("dut8_done_without_expectation", int'(done8), 0);
                    end else begin
                        e = q8.pop_front();
                        check("dut8_done_cycle", cyc, e.due);
                        compare("dut8", int'(pn8), int'(gmin8), int'(gmax8), int'(reg8), int'(ovf8), e);
                        held8 = e;
                    end
                end else begin
                    compare("dut8_hold", int'(pn8), int'(gmin8), int'(gmax8), int'(reg8), int'(ovf8), held8);
                end
                if (done4) begin
                    if (q4.size() == 0) begin
                        check("dut4_done_without_expectation", int'(done4), 0);
                    end else begin
                        e = q4.pop_front();
                        check("dut4_done_cycle", cyc, e.due);
                        compare("dut4", int'(pn4), int'(gmin4), int'(gmax4), int'(reg4), int'(ovf4), e);
                        held4 = e;
                    end
                end else begin
                    compare("dut4_hold", int'(pn4), int'(gmin4), int'(gmax4), int'(reg4), int'(ovf4), held4);
                end
            end
            if (stim_done) begin
                check("dut8_pending_results", q8.size(), 0);
                check("dut4_pending_results", q4.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Drive one clock's worth of inputs; they are applied after a falling edge.
    task automatic step(input logic e_in, input logic r_in, input logic a8, input logic a4);
        en  = e_in;
        rst = r_in;
        p8  = a8;
        p4  = a4;
        @(negedge ck);
    endtask

    // Called just before driving a window's last position: DONE follows the next edge.
    task automatic push8(input int pn, input int gmin, input int gmax, input int rg, input int ov);
        exp_t e;
        e = '{pulse_n: pn, gmin: gmin, gmax: gmax, regular: rg, ovf: ov, due: cyc + 1};
        q8.push_back(e);
    endtask

    task automatic push4(input int pn, input int gmin, input int gmax, input int rg, input int ov);
        exp_t e;
        e = '{pulse_n: pn, gmin: gmin, gmax: gmax, regular: rg, ovf: ov, due: cyc + 1};
        q4.push_back(e);
    endtask

    initial begin
        int  acc;
        logic pl;
        xarst = 1'b0;
        en    = 1'b1;
        rst   = 1'b0;
        p8    = 1'b0;
        p4    = 1'b0;
        gate8 = '0;
        gate4 = '0;
        repeat (3) @(negedge ck);
        xarst = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Constant pulses, GATE=16: every gap is 1 and DONE lands every 16 cycles.
        gate8 = 8'd16;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 48; k++) begin
            if (k % 16 == 15) push8(16, 1, 1, 1, 0);
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end

        // 3-in-7 fractional divider output, GATE=70: gaps 2,2,3.
        gate8 = 8'd70;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        acc = 0;
        for (int k = 0; k < 140; k++) begin
            acc = acc + 3;
            pl  = (acc >= 7);
            if (pl) acc = acc - 7;
            if (k % 70 == 69) push8(30, 2, 3, 1, 0);
            step(1'b1, 1'b0, pl, 1'b0);
        end

        // Alternating gaps 1 and 5, GATE=24.
        gate8 = 8'd24;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 48; k++) begin
            if (k % 24 == 23) push8(8, 1, 5, 0, 0);
            step(1'b1, 1'b0, (k % 6) < 2, 1'b0);
        end

        // Every third enabled cycle, GATE=10, clock enable always on.
        gate8 = 8'd10;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 9)  push8(4, 3, 3, 1, 0);
            if (k == 19) push8(3, 3, 3, 1, 0);
            step(1'b1, 1'b0, (k % 3) == 0, 1'b0);
        end

        // Same enabled-cycle pattern with EN toggling; disabled cycles carry junk pulses.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 9)  push8(4, 3, 3, 1, 0);
            if (k == 19) push8(3, 3, 3, 1, 0);
            step(1'b1, 1'b0, (k % 3) == 0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Synchronous restart mid-window: results held, no DONE until a full window later.
        gate8 = 8'd16;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) push8(16, 1, 1, 1, 0);
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) push8(8, 2, 2, 1, 0);
            step(1'b1, 1'b0, (k % 2) == 1, 1'b0);
        end

        // 4-bit instance: one pulse, 20 idle cycles, then a closing pulse, GATE=15.
        gate8 = '0;
        gate4 = 4'd15;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            if (k == 14) push4(1, 0, 0, 0, 1);
            if (k == 29) push4(1, 15, 15, 1, 1);
            step(1'b1, 1'b0, 1'b0, (k == 0) || (k == 21));
        end
        gate4 = '0;
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-window: outputs clear, next full window starts at release.
        gate8 = 8'd16;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
        xarst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        xarst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) push8(4, 4, 4, 1, 0);
            step(1'b1, 1'b0, (k % 4) == 0, 1'b0);
        end

        gate8 = '0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        stim_done = 1'b1;
    end

endmodule
